// File: rtl/inst_sram_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : inst_sram_if
// Brief    : Instruction-side SRAM bus bundle between fetch stage and memory.
// Revision : 1.0 - initial release
// ============================================================================
interface inst_sram_if;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        inst_sram_err;

    modport master (
        output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, inst_sram_err
    );

    modport slave (
        input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, inst_sram_err
    );
endinterface
`default_nettype wire

// File: rtl/inst_sram_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : inst_sram_responder
// Brief    : Instruction SRAM responder with byte-enabled writes and an
//            optional fixed wait-state latency (macro INST_SRAM_WAIT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module inst_sram_responder #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'hbfc00000,
    parameter int          LATENCY    = 3
) (
    input  logic       clk,
    input  logic       resetn,
    inst_sram_if.slave bus
);

    localparam int unsigned c_DEPTH   = 1 << ADDR_WIDTH;
    localparam int          c_LAT_CFG = (LATENCY < 1) ? 1 : LATENCY;
`ifdef INST_SRAM_WAIT_EN
    localparam int          c_L_EFF   = c_LAT_CFG;
`else
    // Wait states stripped: latency clamps to a single cycle.
    localparam int          c_L_EFF   = (c_LAT_CFG < 1) ? c_LAT_CFG : 1;
`endif
    localparam logic [29-ADDR_WIDTH:0] c_BASE_TAG = BASE_ADDR[31:ADDR_WIDTH+2];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [31:0]           r_mem [c_DEPTH];
    logic [ADDR_WIDTH-1:0] r_idx;
    logic                  r_is_rd;
    logic                  r_oor;
    logic [31:0]           r_rdata;

    logic                  w_addr_ok;
    logic                  w_accept;
    logic                  w_in_range;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_from_wait;
    logic                  w_src_is_rd;
    logic                  w_src_oor;
    logic [ADDR_WIDTH-1:0] w_src_idx;
    logic                  w_load_rdata;
    logic                  w_unused;

    assign w_unused   = ^bus.inst_sram_addr[1:0];
    assign w_in_range = (bus.inst_sram_addr[31:ADDR_WIDTH+2] == c_BASE_TAG);
    assign w_idx      = bus.inst_sram_addr[ADDR_WIDTH+1:2];
    assign w_addr_ok  = (r_state != ST_WAIT);
    // Gated by resetn so a request held during reset never touches the array.
    assign w_accept   = resetn && bus.inst_sram_en && w_addr_ok;

`ifdef INST_SRAM_WAIT_EN
    localparam int c_CW = (c_L_EFF > 1) ? $clog2(c_L_EFF) : 1;
    logic [c_CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= c_CW'(c_L_EFF - 1);
        end else if ((r_state == ST_WAIT) && (r_cnt != c_CW'(1))) begin
            r_cnt <= r_cnt - c_CW'(1);
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_RESP: begin
                if (w_accept) begin
                    w_state_nxt = (c_L_EFF > 1) ? ST_WAIT : ST_RESP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
`ifdef INST_SRAM_WAIT_EN
                if (r_cnt == c_CW'(1)) begin
                    w_state_nxt = ST_RESP;
                end
`else
                w_state_nxt = ST_RESP;
`endif
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_idx   <= '0;
            r_is_rd <= 1'b0;
            r_oor   <= 1'b0;
        end else if (w_accept) begin
            r_idx   <= w_idx;
            r_is_rd <= (bus.inst_sram_wen == 4'b0000);
            r_oor   <= !w_in_range;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept && w_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.inst_sram_wen[b]) begin
                    r_mem[w_idx][8*b +: 8] <= bus.inst_sram_wdata[8*b +: 8];
                end
            end
        end
    end

    // Entry into RESP comes from WAIT (captured request) or straight from an
    // accept when the latency is one cycle (live request).
    assign w_from_wait  = (r_state == ST_WAIT);
    assign w_src_is_rd  = w_from_wait ? r_is_rd : (bus.inst_sram_wen == 4'b0000);
    assign w_src_oor    = w_from_wait ? r_oor   : !w_in_range;
    assign w_src_idx    = w_from_wait ? r_idx   : w_idx;
    assign w_load_rdata = (w_state_nxt == ST_RESP) && w_src_is_rd;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rdata <= 32'h0;
        end else if (w_load_rdata) begin
            r_rdata <= w_src_oor ? 32'h0 : r_mem[w_src_idx];
        end
    end

    assign bus.inst_sram_addr_ok = w_addr_ok;
    assign bus.inst_sram_data_ok = (r_state == ST_RESP);
    assign bus.inst_sram_err     = (r_state == ST_RESP) && r_oor;
    assign bus.inst_sram_rdata   = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_inst_sram_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_inst_sram_responder
// Brief    : Directed bench for inst_sram_responder with a cycle-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_sram_responder;

    localparam logic [31:0] c_BASE = 32'hbfc00000;
`ifdef INST_SRAM_WAIT_EN
    localparam int c_EXP_LAT = 3;
`else
    localparam int c_EXP_LAT = 1;
`endif

    logic clk;
    logic resetn;
    int   n_chk;
    int   n_fail;

    inst_sram_if bus ();

    inst_sram_responder #(
        .ADDR_WIDTH (10),
        .BASE_ADDR  (c_BASE),
        .LATENCY    (3)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: per accepted request, the response appears after edge T+L-1.
    logic [31:0] m_mem [1024];
    int          m_n;
    bit          m_pend;
    int          m_due;
    bit          m_isrd;
    bit          m_oor;
    logic [31:0] m_rval;
    logic [31:0] m_rdata;
    bit          m_aok;
    bit          m_dok;
    bit          m_err;

    initial begin
        m_n = 0; m_pend = 0; m_due = 0; m_isrd = 0; m_oor = 0;
        m_rval = 32'h0; m_rdata = 32'h0; m_aok = 1; m_dok = 0; m_err = 0;
    end

    always @(posedge clk) begin
        logic [31:0] off;
        int          idx;
        m_n++;
        if (!resetn) begin
            m_pend = 0; m_rdata = 32'h0; m_aok = 1; m_dok = 0; m_err = 0;
        end else begin
            if (bus.inst_sram_en && m_aok) begin
                off    = bus.inst_sram_addr - c_BASE;
                m_oor  = !(off < 32'd4096);
                idx    = int'(off >> 2);
                m_isrd = (bus.inst_sram_wen == 4'b0000);
                if (m_isrd) begin
                    m_rval = m_oor ? 32'h0 : m_mem[idx];
                end else if (!m_oor) begin
                    for (int b = 0; b < 4; b++)
                        if (bus.inst_sram_wen[b])
                            m_mem[idx][8*b +: 8] = bus.inst_sram_wdata[8*b +: 8];
                end
                m_pend = 1;
                m_due  = m_n + c_EXP_LAT - 1;
            end
            m_dok = m_pend && (m_n == m_due);
            m_err = m_dok && m_oor;
            if (m_dok && m_isrd) m_rdata = m_rval;
            m_aok = !(m_pend && (m_n < m_due));
            if (m_pend && (m_n >= m_due)) m_pend = 0;
        end
    end

    always @(negedge clk) begin
        if (!resetn) begin
            chk("rst addr_ok", {31'b0, bus.inst_sram_addr_ok}, 32'd1);
            chk("rst data_ok", {31'b0, bus.inst_sram_data_ok}, 32'd0);
            chk("rst err",     {31'b0, bus.inst_sram_err},     32'd0);
            chk("rst rdata",   bus.inst_sram_rdata,            32'h0);
        end else begin
            chk("addr_ok", {31'b0, bus.inst_sram_addr_ok}, {31'b0, m_aok});
            chk("data_ok", {31'b0, bus.inst_sram_data_ok}, {31'b0, m_dok});
            chk("err",     {31'b0, bus.inst_sram_err},     {31'b0, m_err});
            chk("rdata",   bus.inst_sram_rdata,            m_rdata);
        end
    end

    // Called at posedge+1; returns at posedge+1 of the response cycle.
    task automatic do_req(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic e);
        bit acc;
        acc = 0;
        bus.inst_sram_en    = 1'b1;
        bus.inst_sram_wen   = w;
        bus.inst_sram_addr  = a;
        bus.inst_sram_wdata = d;
        for (int k = 0; k < 20; k++) begin
            acc = bus.inst_sram_addr_ok;
            @(posedge clk);
            if (acc) break;
        end
        #1;
        bus.inst_sram_en = 1'b0;
        if (!acc) chk("accept timeout", 32'd0, 32'd1);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            if (bus.inst_sram_data_ok) begin
                lat = k;
                break;
            end
            @(posedge clk);
            #1;
        end
        rd = bus.inst_sram_rdata;
        e  = bus.inst_sram_err;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        e;
        n_chk = 0;
        n_fail = 0;
        resetn = 1'b1;
        bus.inst_sram_en    = 1'b0;
        bus.inst_sram_wen   = 4'h0;
        bus.inst_sram_addr  = 32'h0;
        bus.inst_sram_wdata = 32'h0;
        #1 resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("idle rdata", bus.inst_sram_rdata, 32'h0);
        chk("idle addr_ok", {31'b0, bus.inst_sram_addr_ok}, 32'd1);

        do_req(4'hf, 32'hbfc00000, 32'h24080001, lat, rd, e);
        chk("wr0 latency", lat, c_EXP_LAT);
        chk("wr0 rdata held", rd, 32'h0);
        chk("wr0 err", {31'b0, e}, 32'd0);
        do_req(4'hf, 32'hbfc00004, 32'h11223344, lat, rd, e);
        do_req(4'hf, 32'hbfc00008, 32'h00002021, lat, rd, e);
        do_req(4'hf, 32'hbfc00ffc, 32'hdeadbeef, lat, rd, e);

        do_req(4'h0, 32'hbfc00000, 32'h0, lat, rd, e);
        chk("rd0 latency", lat, c_EXP_LAT);
        chk("rd0 data", rd, 32'h24080001);

        do_req(4'b0101, 32'hbfc00004, 32'haabbccdd, lat, rd, e);
        chk("byte wr rdata held", rd, 32'h24080001);
        do_req(4'h0, 32'hbfc00004, 32'h0, lat, rd, e);
        chk("byte lanes", rd, 32'h11bb33dd);

        do_req(4'h0, 32'h00000000, 32'h0, lat, rd, e);
        chk("oor rd err", {31'b0, e}, 32'd1);
        chk("oor rd data", rd, 32'h0);
        do_req(4'hf, 32'hbfc01000, 32'h12345678, lat, rd, e);
        chk("oor wr err", {31'b0, e}, 32'd1);
        do_req(4'h0, 32'hbfc00000, 32'h0, lat, rd, e);
        chk("no alias after oor", rd, 32'h24080001);
        chk("in-range err", {31'b0, e}, 32'd0);
        do_req(4'h0, 32'hbfc00ffc, 32'h0, lat, rd, e);
        chk("last word", rd, 32'hdeadbeef);

`ifndef INST_SRAM_WAIT_EN
        bus.inst_sram_wen  = 4'h0;
        bus.inst_sram_en   = 1'b1;
        bus.inst_sram_addr = 32'hbfc00000;
        @(posedge clk); #1;
        bus.inst_sram_addr = 32'hbfc00004;
        chk("b2b 0 data_ok", {31'b0, bus.inst_sram_data_ok}, 32'd1);
        chk("b2b 0 data", bus.inst_sram_rdata, 32'h24080001);
        @(posedge clk); #1;
        bus.inst_sram_addr = 32'hbfc00008;
        chk("b2b 1 data_ok", {31'b0, bus.inst_sram_data_ok}, 32'd1);
        chk("b2b 1 data", bus.inst_sram_rdata, 32'h11bb33dd);
        @(posedge clk); #1;
        bus.inst_sram_en = 1'b0;
        chk("b2b 2 data_ok", {31'b0, bus.inst_sram_data_ok}, 32'd1);
        chk("b2b 2 data", bus.inst_sram_rdata, 32'h00002021);
        @(posedge clk); #1;
        chk("b2b end data_ok", {31'b0, bus.inst_sram_data_ok}, 32'd0);
`else
        bus.inst_sram_wen  = 4'h0;
        bus.inst_sram_addr = 32'hbfc00004;
        bus.inst_sram_en   = 1'b1;
        @(posedge clk); #1;
        bus.inst_sram_en = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        chk("midrst data_ok", {31'b0, bus.inst_sram_data_ok}, 32'd0);
        chk("midrst rdata", bus.inst_sram_rdata, 32'h0);
        @(posedge clk); #1;
        resetn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("post rst no data_ok", {31'b0, bus.inst_sram_data_ok}, 32'd0);
        end
        chk("post rst rdata", bus.inst_sram_rdata, 32'h0);
        do_req(4'h0, 32'hbfc00004, 32'h0, lat, rd, e);
        chk("post rst read", rd, 32'h11bb33dd);
        chk("post rst latency", lat, 3);
`endif

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
